im_loader: RTL
==============

Name: im_loader

Overview:
- Write-side companion to the instruction memory.
- Accepts a byte stream on a valid/ready handshake, for example from a UART receiver or host bridge.
- Assembles the bytes into 32-bit instruction words and drives a one-cycle write strobe into the instruction memory's write port at consecutive word indices.
- Holds the processor (via busy) while a program image is being loaded, and reports done or error.

Parameters:
- DEPTH, 128: number of 32-bit instruction-memory entries.
- AW, 7: word-index width; must satisfy 2**AW >= DEPTH.
- TIMEOUT, 65535: maximum idle cycles between accepted bytes during a load before aborting.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  AW  word index for the write; the 8-byte stride of the read side is not applied here.
- mem_data  out  32  word to write.
- busy  out  1  load in progress; used to hold the CPU.
- done  out  1  sticky: load completed successfully.
- err  out  1  sticky: load aborted.
- words_written  out  AW+1  count of words committed in the current or last load.

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE.
  - All outputs are 0, including in_ready, mem_we, busy, done, err and words_written.
  - Any partially assembled word is discarded; no write is issued.
  - The same applies when rst asserts mid-load.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is a registered state decode, not combinationally dependent on in_valid.
- FSM states: IDLE, HDR, LOAD, WRITE, DONE, ERR.
  - IDLE/DONE/ERR with start=1:
    - go to HDR.
    - Clear done, err, words_written, the byte counter and the timeout counter.
    - Set busy=1.
  - HDR:
    - in_ready=1.
    - Accept 2 bytes forming a big-endian 16-bit word count N.
    - After the 2nd byte: N==0 goes to DONE; N>DEPTH goes to ERR; otherwise go to LOAD with mem_addr=0.
  - LOAD:
    - in_ready=1.
    - Accept bytes most-significant byte first into a 32-bit shift register.
    - On acceptance of the 4th byte, go to WRITE.
  - WRITE (exactly one cycle):
    - mem_we=1, mem_data=assembled word, in_ready=0.
    - On exit, increment words_written and mem_addr.
    - If words_written+1==N, go to DONE; otherwise go to LOAD.
- Latency: mem_we asserts in the cycle immediately after the edge that accepted the 4th byte of a word.
- mem_addr and mem_data:
  - Stable throughout WRITE.
  - mem_data holds its last value otherwise.
  - mem_we is 0 in every state except WRITE.
- Timeout:
  - The counter runs in HDR and LOAD and clears on every accepted byte.
  - Reaching TIMEOUT goes to ERR. The partial word is not written; already-written words stay.
- DONE: busy=0, done=1, err=0. ERR: busy=0, err=1, done=0. Both hold until the next start or reset.
- start in HDR/LOAD/WRITE is ignored.
- in_valid while in_ready=0 (IDLE, WRITE, DONE, ERR): the byte is not consumed; the source must hold it.
- mem_addr cannot wrap, because N<=DEPTH is enforced in HDR.

Decomposition:
- Shared package im_pkg holds:
  - the state enum (IDLE, HDR, LOAD, WRITE, DONE, ERR);
  - IM_DEPTH=128 and IM_AW=7, shared with the instruction memory;
  - header width constant HDR_BYTES=2.
- One natural sub-module, im_word_pack:
  - 8-to-32 big-endian byte packer with a 2-bit byte counter;
  - asserts word_full after the 4th byte;
  - clear input driven by the FSM on start and on reset.

Test Plan:
- Normal load: start, then bytes 00 02 | 20 03 00 03 | 20 08 00 05.
  - mem_we pulses twice: (addr 0, 0x20030003) then (addr 1, 0x20080005).
  - Each pulse occurs one cycle after the 4th byte.
  - Ends with done=1, words_written=2, busy=0.
- Zero count: header 00 00 → DONE in the cycle after the 2nd byte; no mem_we; words_written=0.
- Oversize: header 00 81 (129 > 128) → err=1, no mem_we; a subsequent start with a valid 1-word image succeeds.
- Back-pressure: hold in_valid=1 continuously.
  - in_ready drops during each WRITE cycle and no byte is lost.
  - A 3-word image with bytes 0x01..0x0C yields words 0x01020304, 0x05060708, 0x090A0B0C.
- Timeout with TIMEOUT=16: header 00 02, one full word, then 2 bytes and silence.
  - err=1 after 16 idle cycles; words_written=1; no second mem_we.
- Reset mid-load: assert rst after 3 bytes of word 0.
  - All outputs go 0 immediately (asynchronous) and no write occurs.
  - A start after deassertion performs a clean load.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader and the memory itself.
package im_pkg;
  localparam int IM_DEPTH  = 128;
  localparam int IM_AW     = 7;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR
  } im_state_e;
endpackage

// File: rtl/im_word_pack.sv
// Big-endian 8-to-32 byte packer; o_full is high for the cycle after the 4th byte.
module im_word_pack
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full,
  output logic        o_last
);
  logic [31:0] r_sr;
  logic [1:0]  r_cnt;
  logic        r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_full <= i_en && (r_cnt == 2'd3);
      if (i_en) begin
        r_sr  <= {r_sr[23:0], i_byte};
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign o_word = r_sr;
  assign o_full = r_full;
  // Combinational so the FSM can leave LOAD on the same edge that takes byte 4.
  assign o_last = i_en && (r_cnt == 2'd3);
endmodule

// File: rtl/im_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one word per write strobe.
module im_loader
  import im_pkg::*;
#(
  parameter int DEPTH   = IM_DEPTH,
  parameter int AW      = IM_AW,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_written
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int WW = AW + 1;

  im_state_e     r_state, w_next;
  logic          r_hcnt;
  logic [7:0]    r_hdr_hi;
  logic [15:0]   r_n;
  logic [TW-1:0] r_tmo;
  logic [AW-1:0] r_addr;
  logic [WW-1:0] r_wr;
  logic [31:0]   r_hold;

  logic          w_rdy, w_accept, w_start_ok, w_tmo_hit, w_last_word;
  logic          w_pk_en, w_pk_full, w_pk_last;
  logic [31:0]   w_pk_word;
  logic [15:0]   w_n;

  assign w_rdy       = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_accept    = in_valid && w_rdy;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_tmo_hit   = !w_accept && (r_tmo == TW'(TIMEOUT - 1));
  assign w_n         = {r_hdr_hi, in_data};
  assign w_last_word = (16'(r_wr) + 16'd1) == r_n;
  assign w_pk_en     = w_accept && (r_state == S_LOAD);

  im_word_pack u_pack (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_en   (w_pk_en),
    .i_byte (in_data),
    .o_word (w_pk_word),
    .o_full (w_pk_full),
    .o_last (w_pk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    mem_we = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_HDR;
      S_HDR: begin
        busy = 1'b1;
        if (w_accept && (r_hcnt == 1'(HDR_BYTES - 1))) begin
          if (w_n == 16'd0)             w_next = S_DONE;
          else if (w_n > 16'(DEPTH))    w_next = S_ERR;
          else                          w_next = S_LOAD;
        end else if (w_tmo_hit)         w_next = S_ERR;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (w_pk_last)      w_next = S_WRITE;
        else if (w_tmo_hit) w_next = S_ERR;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        w_next = w_last_word ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) w_next = S_HDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt   <= 1'b0;
      r_hdr_hi <= '0;
      r_n      <= '0;
      r_tmo    <= '0;
      r_addr   <= '0;
      r_wr     <= '0;
      r_hold   <= '0;
    end else begin
      if (w_start_ok) begin
        r_hcnt <= 1'b0;
        r_tmo  <= '0;
        r_wr   <= '0;
      end else begin
        if (w_accept)   r_tmo <= '0;
        else if (w_rdy) r_tmo <= r_tmo + TW'(1);
        if (w_accept && (r_state == S_HDR)) begin
          if (r_hcnt == 1'(HDR_BYTES - 1)) begin
            r_n    <= w_n;
            r_hcnt <= 1'b0;
            r_addr <= '0;
          end else begin
            r_hdr_hi <= in_data;
            r_hcnt   <= 1'b1;
          end
        end
        if (r_state == S_WRITE) begin
          r_wr   <= r_wr + WW'(1);
          r_addr <= r_addr + AW'(1);
        end
      end
      if (w_pk_full) r_hold <= w_pk_word;
    end
  end

  // The packer's full flag coincides with WRITE, so the live word is shown there
  // and the captured copy is held everywhere else.
  assign mem_data      = w_pk_full ? w_pk_word : r_hold;
  assign mem_addr      = r_addr;
  assign in_ready      = w_rdy;
  assign words_written = r_wr;
endmodule
